// File: rtl/alu_result_skid.sv
// Two-entry skid buffer between the ALU result and the memory stage, with a registered in_ready.
// Build option ALU_SKID_PARITY_EN adds a per-entry even-parity bit on out_parity.
module alu_result_skid #(
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_result,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic                   in_ovf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_result,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   out_ovf,
`ifdef ALU_SKID_PARITY_EN
    output logic                   out_parity,
`endif
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // state | meaning
    // EMPTY | no entries held
    // ONE   | main entry valid, drives out_*
    // TWO   | main and skid valid, in_ready low
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t state, state_nxt;
    logic   in_fire, out_fire;
    logic   load_main_in, load_skid_in, load_main_skid;

    logic [DATA_W-1:0] main_result, skid_result;
    logic [TAG_W-1:0]  main_tag, skid_tag;
    logic              main_ovf, skid_ovf;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_nxt    = TWO;
                        load_skid_in = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: if (out_fire) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Outputs depend only on the state register, so in_ready has no path from out_ready.
    always_comb begin
        out_valid = (state == ONE) || (state == TWO);
        in_ready  = (state != TWO);
        occupancy = state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_result <= '0;
            main_tag    <= '0;
            main_ovf    <= 1'b0;
            skid_result <= '0;
            skid_tag    <= '0;
            skid_ovf    <= 1'b0;
        end else begin
            if (load_main_in) begin
                main_result <= in_result;
                main_tag    <= in_tag;
                main_ovf    <= in_ovf;
            end else if (load_main_skid) begin
                main_result <= skid_result;
                main_tag    <= skid_tag;
                main_ovf    <= skid_ovf;
            end
            if (load_skid_in) begin
                skid_result <= in_result;
                skid_tag    <= in_tag;
                skid_ovf    <= in_ovf;
            end
        end
    end

`ifdef ALU_SKID_PARITY_EN
    logic main_parity, skid_parity;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_parity <= 1'b0;
            skid_parity <= 1'b0;
        end else begin
            if (load_main_in)        main_parity <= ^in_result;
            else if (load_main_skid) main_parity <= skid_parity;
            if (load_skid_in)        skid_parity <= ^in_result;
        end
    end

    assign out_parity = main_parity;
`endif

    assign out_result = main_result;
    assign out_tag    = main_tag;
    assign out_ovf    = main_ovf;

    // Flush does not clear the count; it saturates at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_alu_result_skid.sv
// Directed self-checking bench for alu_result_skid; parity checks apply when ALU_SKID_PARITY_EN is defined.
module tb_alu_result_skid;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [4:0]  in_tag;
   logic        in_ovf;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_tag;
   logic        out_ovf;
`ifdef ALU_SKID_PARITY_EN
   logic        out_parity;
`endif
   logic [1:0]  occupancy;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   alu_result_skid #(.DATA_W(32), .TAG_W(5), .STALL_CNT_W(16)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_tag     (in_tag),
      .in_ovf     (in_ovf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .out_ovf    (out_ovf),
`ifdef ALU_SKID_PARITY_EN
      .out_parity (out_parity),
`endif
      .occupancy  (occupancy),
      .stall_cnt  (stall_cnt)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_result = '0;
      in_tag    = '0;
      in_ovf    = 1'b0;
      out_ready = 1'b0;
      #12;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_occ", occupancy, 2'd0);
      check("rst_stall", stall_cnt, 16'h0);
      reset_n = 1'b1;
      #2;

      // Streaming at full rate
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_result = 32'h1; in_tag = 5'd1; in_ovf = 1'b0;
      tick();
      check("stream1_valid", out_valid, 1'b1);
      check("stream1_data", out_result, 32'h1);
      check("stream1_occ", occupancy, 2'd1);
      in_result = 32'h2; in_tag = 5'd2; in_ovf = 1'b1;
      tick();
      check("stream2_data", out_result, 32'h2);
      check("stream2_tag", out_tag, 5'd2);
      check("stream2_ovf", out_ovf, 1'b1);
      check("stream2_occ", occupancy, 2'd1);
      in_result = 32'h3; in_tag = 5'd3; in_ovf = 1'b0;
      tick();
      check("stream3_data", out_result, 32'h3);
      check("stream3_occ", occupancy, 2'd1);
      in_valid = 1'b0;
      tick();
      check("stream_drain_valid", out_valid, 1'b0);
      check("stream_drain_occ", occupancy, 2'd0);
      check("stream_stall", stall_cnt, 16'h0);

      // Fill both entries under stall, then drain in order
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_result = 32'hA5A5A5A5; in_tag = 5'd10; in_ovf = 1'b1;
      tick();
      check("fill1_occ", occupancy, 2'd1);
      check("fill1_data", out_result, 32'hA5A5A5A5);
      check("fill1_in_ready", in_ready, 1'b1);
      check("fill1_stall", stall_cnt, 16'h0);
      in_result = 32'h0000FFFF; in_tag = 5'd20; in_ovf = 1'b0;
      tick();
      check("fill2_occ", occupancy, 2'd2);
      check("fill2_in_ready", in_ready, 1'b0);
      check("fill2_data_hold", out_result, 32'hA5A5A5A5);
      check("fill2_tag_hold", out_tag, 5'd10);
      check("fill2_stall", stall_cnt, 16'h1);
      in_result = 32'hDEADBEEF; in_tag = 5'd31;
      tick();
      check("ignored_occ", occupancy, 2'd2);
      check("ignored_data_hold", out_result, 32'hA5A5A5A5);
      check("ignored_stall", stall_cnt, 16'h2);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("drain1_data", out_result, 32'h0000FFFF);
      check("drain1_tag", out_tag, 5'd20);
      check("drain1_ovf", out_ovf, 1'b0);
      check("drain1_occ", occupancy, 2'd1);
      check("drain1_in_ready", in_ready, 1'b1);
      tick();
      check("drain2_valid", out_valid, 1'b0);
      check("drain2_occ", occupancy, 2'd0);

      // Flush in TWO state with a same-cycle push
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_result = 32'h11; in_tag = 5'd1;
      tick();
      in_result = 32'h22; in_tag = 5'd2;
      tick();
      check("preflush_occ", occupancy, 2'd2);
      check("preflush_stall", stall_cnt, 16'h3);
      flush     = 1'b1;
      in_result = 32'h33; in_tag = 5'd3;
      tick();
      check("flush_occ", occupancy, 2'd0);
      check("flush_valid", out_valid, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      check("flush_stall_kept", stall_cnt, 16'h4);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("postflush_valid", out_valid, 1'b0);
      check("postflush_occ", occupancy, 2'd0);

      // Asynchronous reset while holding two entries
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_result = 32'h44;
      tick();
      in_result = 32'h55;
      tick();
      in_valid = 1'b0;
      check("premid_occ", occupancy, 2'd2);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_occ", occupancy, 2'd0);
      check("midrst_stall", stall_cnt, 16'h0);
      check("midrst_data", out_result, 32'h0);
      #3;
      reset_n = 1'b1;

      // Parity of captured results
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_result = 32'h00000007;
      tick();
      check("par7_data", out_result, 32'h7);
`ifdef ALU_SKID_PARITY_EN
      check("par7_parity", out_parity, 1'b1);
`endif
      in_result = 32'h00000003;
      tick();
      check("par3_data", out_result, 32'h3);
`ifdef ALU_SKID_PARITY_EN
      check("par3_parity", out_parity, 1'b0);
`endif
      in_valid = 1'b0;
      tick();
      check("par_drain_occ", occupancy, 2'd0);

      // Stall counter saturation
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_result = 32'h66;
      tick();
      in_valid = 1'b0;
      check("sat_start", stall_cnt, 16'h0);
      repeat (65534) tick();
      check("sat_minus1", stall_cnt, 16'hFFFE);
      tick();
      check("sat_reach", stall_cnt, 16'hFFFF);
      repeat (10) tick();
      check("sat_hold", stall_cnt, 16'hFFFF);
      check("sat_data_hold", out_result, 32'h66);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
